// File: rtl/mawg_pkg.sv
// Shared types and codes for the MAWG UART command framer.
// Frame: cmd, d3, d2, d1, d0, csum (XOR of all six bytes is zero).
package mawg_pkg;

  typedef enum logic [1:0] {
    S_CMD,
    S_DATA,
    S_CSUM
  } state_t;

  localparam logic [7:0] CMD_00 = 8'd0;
  localparam logic [7:0] CMD_01 = 8'd1;
  localparam logic [7:0] CMD_02 = 8'd2;
  localparam logic [7:0] CMD_03 = 8'd3;
  localparam logic [7:0] CMD_04 = 8'd4;
  localparam logic [7:0] CMD_05 = 8'd5;
  localparam logic [7:0] CMD_06 = 8'd6;
  localparam logic [7:0] CMD_07 = 8'd7;
  localparam logic [7:0] CMD_08 = 8'd8;
  localparam logic [7:0] CMD_09 = 8'd9;
  localparam logic [7:0] CMD_10 = 8'd10;
  localparam logic [7:0] CMD_11 = 8'd11;
  localparam logic [7:0] CMD_12 = 8'd12;

  localparam logic [7:0] CMD_MAX   = CMD_12;
  localparam logic [7:0] CMD_CLEAR = 8'd15;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_CMD     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/mawg_cmd_framer_edge.sv
// Turns the UART_RX busy falling edge into a one-cycle byte strobe.
// Ports: i_clk, i_rst_n, i_busy in; o_stb out.
module byte_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_busy,
  output logic o_stb
);

  logic r_prev_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_prev_busy <= 1'b0;
    else          r_prev_busy <= i_busy;
  end

  assign o_stb = r_prev_busy & ~i_busy;

endmodule

// File: rtl/mawg_cmd_framer.sv
// Assembles 6-byte UART command frames and issues register writes.
// Ports: clk, rst_n, uart_busy, uart_data in; wr_*, clear_all, frame_err, err_* out.
module mawg_cmd_framer
  import mawg_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 20000,
  parameter logic [7:0] MAX_CMD        = CMD_MAX,
  parameter logic [7:0] CLEAR_CMD      = CMD_CLEAR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_busy,
  input  logic [7:0]  uart_data,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        clear_all,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t r_state, w_next;

  logic          w_stb;
  logic          w_tmo;
  logic          w_wr, w_clr, w_drop;
  logic [1:0]    w_code;
  logic [7:0]    r_cmd, r_acc;
  logic [31:0]   r_data;
  logic [1:0]    r_idx;
  logic [TW-1:0] r_tmo;

  logic          r_wr_en, r_clr, r_ferr;
  logic [7:0]    r_wr_addr, r_err_count;
  logic [31:0]   r_wr_data;
  logic [1:0]    r_err_code;

  byte_edge_detect u_edge (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_busy  (uart_busy),
    .o_stb   (w_stb)
  );

  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_tmo = (r_state != S_CMD) && !w_stb && (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CMD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CMD:  if (w_stb) w_next = S_DATA;
      S_DATA: begin
        if (w_stb && r_idx == 2'd3) w_next = S_CSUM;
        else if (w_tmo)             w_next = S_CMD;
      end
      S_CSUM: if (w_stb || w_tmo) w_next = S_CMD;
      default: w_next = S_CMD;
    endcase
  end

  always_comb begin
    w_wr   = 1'b0;
    w_clr  = 1'b0;
    w_drop = 1'b0;
    w_code = ERR_NONE;
    if (r_state == S_CSUM && w_stb) begin
      if ((r_acc ^ uart_data) != 8'd0) begin
        w_drop = 1'b1;
        w_code = ERR_CSUM;
      end else if (r_cmd == CLEAR_CMD) begin
        w_clr = 1'b1;
      end else if (r_cmd > MAX_CMD) begin
        w_drop = 1'b1;
        w_code = ERR_CMD;
      end else begin
        w_wr = 1'b1;
      end
    end
    if (w_tmo) begin
      w_drop = 1'b1;
      w_code = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd  <= '0;
      r_acc  <= '0;
      r_data <= '0;
      r_idx  <= '0;
    end else if (w_stb) begin
      unique case (r_state)
        S_CMD: begin
          r_cmd <= uart_data;
          r_acc <= uart_data;
          r_idx <= '0;
        end
        S_DATA: begin
          r_data <= {r_data[23:0], uart_data};
          r_acc  <= r_acc ^ uart_data;
          r_idx  <= r_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_tmo <= '0;
    else if (w_stb || w_tmo || r_state == S_CMD) r_tmo <= '0;
    else                                        r_tmo <= r_tmo + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en     <= 1'b0;
      r_clr       <= 1'b0;
      r_ferr      <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_err_code  <= ERR_NONE;
      r_err_count <= '0;
    end else begin
      r_wr_en <= w_wr;
      r_clr   <= w_clr;
      r_ferr  <= w_drop;
      if (w_wr) begin
        r_wr_addr <= r_cmd;
        r_wr_data <= r_data;
      end
      if (w_drop) begin
        r_err_code <= w_code;
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign clear_all = r_clr;
  assign frame_err = r_ferr;
  assign err_code  = r_err_code;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_mawg_cmd_framer.sv
// Directed bench for mawg_cmd_framer with a shortened timeout.
// Bytes are framed by a one-cycle busy pulse driven on the falling clock edge.
module tb_mawg_cmd_framer;

  localparam int T = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_busy;
  logic [7:0]  uart_data;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clear_all;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_wr  = 0;
  int n_clr = 0;
  int n_fe  = 0;

  mawg_cmd_framer #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_busy (uart_busy),
    .uart_data (uart_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clear_all (clear_all),
    .frame_err (frame_err),
    .err_code  (err_code),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en)     n_wr++;
    if (clear_all) n_clr++;
    if (frame_err) n_fe++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_data = b;
    uart_busy = 1'b1;
    @(negedge clk);
    uart_busy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, d3, d2, d1, d0, cs);
    send_byte(c);
    send_byte(d3);
    send_byte(d2);
    send_byte(d1);
    send_byte(d0);
    send_byte(cs);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, ".wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, ".wr_data"}, wr_data, 32'd0);
    chk({tag, ".clear"}, 32'(clear_all), 32'd0);
    chk({tag, ".ferr"}, 32'(frame_err), 32'd0);
    chk({tag, ".code"}, 32'(err_code), 32'd0);
    chk({tag, ".count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    int s_fe;
    int s_wr;
    int k;
    rst_n     = 1'b0;
    uart_busy = 1'b0;
    uart_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // 1: valid write
    send_frame(8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03);
    @(negedge clk);
    chk("t1.wr_en", 32'(wr_en), 32'd1);
    chk("t1.addr", 32'(wr_addr), 32'd2);
    chk("t1.data", wr_data, 32'h0001_0000);
    chk("t1.ferr", 32'(frame_err), 32'd0);
    chk("t1.count", 32'(err_count), 32'd0);
    @(negedge clk);
    chk("t1.pulse", 32'(wr_en), 32'd0);

    // 2: bad checksum
    s_wr = n_wr;
    send_frame(8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h04);
    @(negedge clk);
    chk("t2.ferr", 32'(frame_err), 32'd1);
    chk("t2.code", 32'(err_code), 32'd1);
    chk("t2.wr_en", 32'(wr_en), 32'd0);
    chk("t2.count", 32'(err_count), 32'd1);
    @(negedge clk);
    chk("t2.pulse", 32'(frame_err), 32'd0);
    chk("t2.nowr", 32'(n_wr - s_wr), 32'd0);
    chk("t2.hold", wr_data, 32'h0001_0000);

    // 3: bad cmd, clear, highest valid cmd
    send_frame(8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0E);
    @(negedge clk);
    chk("t3.ferr", 32'(frame_err), 32'd1);
    chk("t3.code", 32'(err_code), 32'd2);
    chk("t3.count", 32'(err_count), 32'd2);
    send_frame(8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F);
    @(negedge clk);
    chk("t3.clear", 32'(clear_all), 32'd1);
    chk("t3.clr_wr", 32'(wr_en), 32'd0);
    chk("t3.clr_fe", 32'(frame_err), 32'd0);
    chk("t3.code_hold", 32'(err_code), 32'd2);
    chk("t3.addr_hold", 32'(wr_addr), 32'd2);
    send_frame(8'h0C, 8'h00, 8'h00, 8'h00, 8'h07, 8'h0B);
    @(negedge clk);
    chk("t3.max_wr", 32'(wr_en), 32'd1);
    chk("t3.max_addr", 32'(wr_addr), 32'd12);
    chk("t3.max_data", wr_data, 32'h0000_0007);

    // 4: timeout after two bytes, then recovery
    send_byte(8'h02);
    send_byte(8'h00);
    k = 0;
    for (int i = 1; i <= T + 5; i++) begin
      @(negedge clk);
      if (frame_err) begin
        k = i;
        break;
      end
    end
    chk("t4.tmo_cycle", k, T + 1);
    chk("t4.code", 32'(err_code), 32'd3);
    chk("t4.count", 32'(err_count), 32'd3);
    send_frame(8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0D);
    @(negedge clk);
    chk("t4.wr_en", 32'(wr_en), 32'd1);
    chk("t4.addr", 32'(wr_addr), 32'd5);
    chk("t4.data", wr_data, 32'h1234_5678);

    // 5: byte on the expiry cycle, then long idle
    s_fe = n_fe;
    send_byte(8'h02);
    send_byte(8'h00);
    repeat (T - 2) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h03);
    @(negedge clk);
    chk("t5.wr_en", 32'(wr_en), 32'd1);
    chk("t5.data", wr_data, 32'h0001_0000);
    chk("t5.nofe", n_fe - s_fe, 0);
    chk("t5.count", 32'(err_count), 32'd3);
    s_fe = n_fe;
    repeat (10 * T) @(negedge clk);
    chk("t5.idle", n_fe - s_fe, 0);

    // 6: saturation, then reset mid-frame
    for (int i = 0; i < 300; i++)
      send_frame(8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h04);
    @(negedge clk);
    chk("t6.sat", 32'(err_count), 32'd255);
    chk("t6.code", 32'(err_code), 32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    s_fe = n_fe;
    send_frame(8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0D);
    @(negedge clk);
    chk("t6.wr_en", 32'(wr_en), 32'd1);
    chk("t6.addr", 32'(wr_addr), 32'd5);
    chk("t6.data", wr_data, 32'h1234_5678);
    chk("t6.count", 32'(err_count), 32'd0);
    chk("t6.nofe", n_fe - s_fe, 0);
    chk("excl", 32'(n_clr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
